// File: rtl/scoreboard_pkg.sv
// Shared scoreboard types and entry-state encoding.
// Imported by the scoreboard and by the forwarding unit.
package scoreboard_pkg;

  localparam int REG_CNT = 8;
  localparam int ST_W    = 3;

  typedef logic [2:0]      reg_idx_t;
  typedef logic [ST_W-1:0] sb_state_t;

  localparam sb_state_t SB_READY = 3'd0;
  localparam sb_state_t SB_WB    = 3'd1;
  localparam sb_state_t SB_MEM   = 3'd2;
  localparam sb_state_t SB_EX    = 3'd3;

endpackage

// File: rtl/sb_entry.sv
// One pending-write entry: loads on an issue hit, otherwise counts down to ready.
// Latency: state is registered, and state_nxt is the combinational next value.
// Backpressure: none. Ageing never pauses because only ID stalls.
module sb_entry #(
  parameter int            ST_W     = 3,
  parameter logic [ST_W-1:0] LOAD_VAL = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic            age_en,
  output logic [ST_W-1:0] state,
  output logic [ST_W-1:0] state_nxt
);
  import scoreboard_pkg::*;

  // An issue hit overrides any older count, so the youngest producer wins.
  always_comb begin
    state_nxt = state;
    if (load) begin
      state_nxt = LOAD_VAL;
    end else if (age_en && (state != '0)) begin
      state_nxt = state - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= '0;
    end else begin
      state <= state_nxt;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Per-register pending-write table feeding forwarding and hazard-lock logic.
// Latency: an issue at edge N is visible after N, and the entry reaches 0 after N+3. No backpressure is applied.
// Optional SCOREBOARD_STATS_EN adds saturating lock_cycles and wb_retires counters.
module reg_scoreboard #(
  parameter int                REG_CNT     = scoreboard_pkg::REG_CNT,
  parameter int                ST_W        = scoreboard_pkg::ST_W,
  parameter logic [ST_W-1:0]   ISSUE_STATE = 3
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            issue_valid,
  input  logic                            issue_regwrite,
  input  logic [$clog2(REG_CNT)-1:0]      issue_rd,
  input  logic                            stall,
  input  logic                            flush,
  output logic [REG_CNT-1:0][ST_W-1:0]    register_invalid,
  output logic                            any_pending
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [15:0]                     lock_cycles,
  output logic [15:0]                     wb_retires
`endif
);
  import scoreboard_pkg::*;

  localparam int IDX_W = $clog2(REG_CNT);

  logic                         issue_go;
  logic [REG_CNT-1:0]           hit;
  logic [REG_CNT-1:0]           retire;
  logic [REG_CNT-1:0][ST_W-1:0] state_nxt;

  assign issue_go = issue_valid && issue_regwrite && !stall && !flush;

  for (genvar i = 0; i < REG_CNT; i++) begin : g_entry
    assign hit[i]    = issue_go && (issue_rd == IDX_W'(i));
    assign retire[i] = (register_invalid[i] == ST_W'(SB_WB)) &&
                       (state_nxt[i] == ST_W'(SB_READY));

    sb_entry #(
      .ST_W     (ST_W),
      .LOAD_VAL (ISSUE_STATE)
    ) u_entry (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (hit[i]),
      .age_en    (1'b1),
      .state     (register_invalid[i]),
      .state_nxt (state_nxt[i])
    );
  end

  // Derived from the next state so that it lines up with register_invalid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      any_pending <= 1'b0;
    end else begin
      any_pending <= |state_nxt;
    end
  end

`ifdef SCOREBOARD_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_cycles <= '0;
      wb_retires  <= '0;
    end else begin
      if (stall && (lock_cycles != 16'hFFFF)) begin
        lock_cycles <= lock_cycles + 16'd1;
      end
      if ((|retire) && (wb_retires != 16'hFFFF)) begin
        wb_retires <= wb_retires + 16'd1;
      end
    end
  end
`else
  logic unused_retire;
  assign unused_retire = ^retire;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomised scoreboard bench: the stimulus pushes expected tables and a negedge monitor pops and compares them.
// The reference model tracks the edge of each register's youngest write issue.
module tb_reg_scoreboard;

  typedef struct packed {
    logic [7:0][2:0] st;
    logic            ap;
    logic [15:0]     lock;
    logic [15:0]     ret;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            issue_valid, issue_regwrite, stall, flush;
  logic [2:0]      issue_rd;
  logic [7:0][2:0] register_invalid;
  logic            any_pending;
`ifdef SCOREBOARD_STATS_EN
  logic [15:0]     lock_cycles, wb_retires;
`endif

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .issue_valid      (issue_valid),
    .issue_regwrite   (issue_regwrite),
    .issue_rd         (issue_rd),
    .stall            (stall),
    .flush            (flush),
    .register_invalid (register_invalid),
    .any_pending      (any_pending)
`ifdef SCOREBOARD_STATS_EN
    ,
    .lock_cycles      (lock_cycles),
    .wb_retires       (wb_retires)
`endif
  );

  int   last_iss [8];
  int   cyc;
  int   m_lock, m_ret;
  exp_t exp_q [$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // An entry equals 3 minus the number of edges since its youngest writer issued, floored at 0.
  function automatic exp_t model_now();
    exp_t e;
    int   age;
    e = '0;
    for (int r = 0; r < 8; r++) begin
      age = cyc - last_iss[r];
      e.st[r] = (age >= 0 && age <= 3) ? 3'(3 - age) : 3'd0;
      if (e.st[r] != 0) e.ap = 1'b1;
    end
    e.lock = 16'(m_lock);
    e.ret  = 16'(m_ret);
    return e;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 8; r++) last_iss[r] = -100;
    cyc    = 0;
    m_lock = 0;
    m_ret  = 0;
  endtask

  task automatic step(input logic v, input logic rw, input logic [2:0] rd,
                      input logic st, input logic fl);
    bit ret_any;
    @(negedge clk);
    issue_valid = v; issue_regwrite = rw; issue_rd = rd; stall = st; flush = fl;
    @(posedge clk);
    cyc++;
    if (v && rw && !st && !fl) last_iss[rd] = cyc;
    if (st && m_lock < 65535) m_lock++;
    ret_any = 1'b0;
    for (int r = 0; r < 8; r++) if (cyc - last_iss[r] == 3) ret_any = 1'b1;
    if (ret_any && m_ret < 65535) m_ret++;
    exp_q.push_back(model_now());
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    for (int r = 0; r < 8; r++)
      chk($sformatf("%s_entry%0d", tag, r), int'(register_invalid[r]), 0);
    chk($sformatf("%s_any_pending", tag), int'(any_pending), 0);
`ifdef SCOREBOARD_STATS_EN
    chk($sformatf("%s_lock_cycles", tag), int'(lock_cycles), 0);
    chk($sformatf("%s_wb_retires", tag), int'(wb_retires), 0);
`endif
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      for (int r = 0; r < 8; r++)
        chk($sformatf("entry%0d", r), int'(register_invalid[r]), int'(e.st[r]));
      chk("any_pending", int'(any_pending), int'(e.ap));
`ifdef SCOREBOARD_STATS_EN
      chk("lock_cycles", int'(lock_cycles), int'(e.lock));
      chk("wb_retires", int'(wb_retires), int'(e.ret));
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1);
  end

  initial begin
    model_reset();
    reset_n = 1'b0;
    issue_valid = 1'b0; issue_regwrite = 1'b0; issue_rd = 3'd0; stall = 1'b0; flush = 1'b0;
    #2;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    idle(2);
    step(1'b1, 1'b1, 3'd5, 1'b0, 1'b0);
    idle(4);
    step(1'b1, 1'b1, 3'd2, 1'b0, 1'b0);
    step(1'b1, 1'b1, 3'd2, 1'b0, 1'b0);
    idle(4);
    step(1'b1, 1'b1, 3'd4, 1'b1, 1'b0);
    step(1'b1, 1'b1, 3'd4, 1'b0, 1'b1);
    step(1'b1, 1'b0, 3'd4, 1'b0, 1'b0);
    step(1'b1, 1'b1, 3'd4, 1'b1, 1'b1);
    idle(2);
    step(1'b1, 1'b1, 3'd1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 3'd2, 1'b0, 1'b0);
    step(1'b1, 1'b1, 3'd3, 1'b0, 1'b0);

    // Assert reset asynchronously while entries 1..3 are still pending.
    @(negedge clk);
    #1;
    issue_valid = 1'b0; issue_regwrite = 1'b0; stall = 1'b0; flush = 1'b0;
    chk("pre_reset_any_pending", int'(any_pending), int'(model_now().ap));
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    #1;
    reset_n = 1'b1;

    idle(2);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    idle(2);

    for (int k = 0; k < 400; k++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 7) == 0));
    idle(5);

    repeat (3) @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Producer of the per-register pending-write table `register_invalid[7:0]` that the forwarding unit consumes.
- Marks a destination register busy when a writing instruction leaves ID.
- Ages each entry one step per cycle as the instruction moves EX -> MEM -> WB, and retires it when the write lands.
- Sits beside the ID stage; its outputs feed forwarding and hazard-lock logic combinationally.

Parameters:
- REG_CNT, 8, number of architectural registers (index width = $clog2(REG_CNT)).
- ST_W, 3, width of each entry's state field.
- ISSUE_STATE, 3, value loaded on issue (instruction now in EX).

Ports:
- clk  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  instruction in ID is leaving ID this cycle.
- issue_regwrite  in  1  that instruction writes a register.
- issue_rd  in  3  its destination register.
- stall  in  1  ID held this cycle; the issue is suppressed and a bubble enters EX.
- flush  in  1  instruction entering EX is squashed; the issue is suppressed.
- register_invalid  out  3 x [7:0]  per-register state: 0 ready, 1 in WB, 2 in MEM, 3 in EX.
- any_pending  out  1  OR over all entries != 0.

Behaviour:
- Reset:
  - Asynchronous on reset_n low; all entries and any_pending go to 0 immediately.
  - Leaving reset: the first update happens at the first rising clk edge with reset_n high.
- Outputs are registered entries driven directly, with no combinational path from inputs. Consumers see the new state the cycle after the edge.
- Per-entry next state at each rising edge, in priority order:
  1. Issue hit: issue_valid & issue_regwrite & !stall & !flush & issue_rd == i -> ISSUE_STATE.
  2. Entry != 0 -> entry - 1. EX, MEM and WB always advance; a stall only freezes ID.
  3. Otherwise hold at 0.
- Write-after-write: an issue hit overrides an older pending count on the same register. The entry reloads to 3; the older writer's remaining count is discarded, since forwarding must pick the youngest producer.
- Issue and ageing in the same cycle on the same register: the issue wins.
- Latency: issue at edge N -> entry = 3 after N, 2 after N+1, 1 after N+2, 0 after N+3.
- stall and flush both asserted: no issue; ageing proceeds normally.
- Entries never underflow; 0 is terminal until the next issue.
- Only values 0..3 are reachable. Values 4..7 are illegal; if present, they decrement like any other nonzero value.
- any_pending is registered: it is computed from the next-state vector, so it is coincident with register_invalid.
- Reset mid-operation: all pending state is lost and no recovery is attempted. The pipeline is reset at the same time.

Optional Feature:
- Macro: SCOREBOARD_STATS_EN.
- When defined:
  - Adds output lock_cycles (16 bits): counts edges where stall is high, saturating at 16'hFFFF.
  - Adds output wb_retires (16 bits): counts edges where any entry transitions 1 -> 0, one count per edge regardless of how many entries retire; saturating.
  - Both counters reset to 0 on reset_n low.
- When undefined: neither port nor counter exists, and core behaviour is identical.

Decomposition:
- Package scoreboard_pkg holds:
  - REG_CNT and ST_W.
  - Typedef reg_idx_t (logic [2:0]).
  - Typedef sb_state_t (logic [ST_W-1:0]).
  - State constants SB_READY=0, SB_WB=1, SB_MEM=2, SB_EX=3.
- The forwarding unit imports the same constants.
- One sub-module, sb_entry:
  - Holds a single entry's register.
  - Inputs: load hit, ageing rule.
  - Output: state.
  - Instantiated REG_CNT times via generate.

Test Plan:
- Reset check: assert reset_n low mid-cycle with entries nonzero -> all register_invalid = 0 and any_pending = 0 without waiting for a clock edge.
- Basic ageing: single issue rd=5 at edge N -> entry[5] reads 3, 2, 1, 0 on successive cycles; other entries stay 0; any_pending falls after N+3.
- Write-after-write: issue rd=2 at edge N, issue rd=2 again at N+1 -> entry[2] = 3, 3, 2, 1, 0.
- Suppression: issue rd=4 with stall=1 -> entry[4] stays 0. Repeat with flush=1, and with issue_regwrite=0 -> same result.
- Pipelined mix: back-to-back issues rd=1, 2, 3 on consecutive edges -> after the third edge, entries 1/2/3 read 1/2/3 respectively.
- Stats (SCOREBOARD_STATS_EN defined): hold stall for 5 edges -> lock_cycles = 5. Retire two registers on the same edge -> wb_retires increments by 1.
